fifo_wr_front: RTL

//  Write-domain front end of the async FIFO, sitting directly upstream of the write-pointer block.

---
 rtl/fifo_wr_front.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_wr_front.sv
// fifo_wr_front: write-domain front end of an async FIFO (skid buffer, rptr sync, fill level)
// Optional feature macro: FIFO_WR_STALL_CNT_EN enables the saturating wfull stall counter.
// Ports:
//   wclk, wrst                          write clock, async active-low reset
//   in_valid_i, in_data_i, in_ready_o   upstream valid/ready stream, in_ready_o registered
//   rptr_async_i                        Gray read pointer from the rclk domain
//   rptr_sync_o                         rptr_async_i after SYNC_STAGES wclk flops
//   wptr_i, wfull_i                     Gray write pointer and full flag from write-pointer block
//   winc_o, wdata_o                     write strobe and data to write-pointer block / memory
//   wfill_o, walmost_full_o             registered wclk-view occupancy and almost-full
//   wstall_cnt_o                        cycles with a word pending while wfull_i is high
module fifo_wr_front #(
  parameter int DEPTH       = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic                   wclk,
  input  logic                   wrst,
  input  logic                   in_valid_i,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   in_ready_o,
  input  logic [$clog2(DEPTH):0] rptr_async_i,
  output logic [$clog2(DEPTH):0] rptr_sync_o,
  input  logic [$clog2(DEPTH):0] wptr_i,
  input  logic                   wfull_i,
  output logic                   winc_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [$clog2(DEPTH):0] wfill_o,
  output logic                   walmost_full_o,
  output logic [15:0]            wstall_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic in_ready_q, walmost_full_q, accept;
  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] wfill_q, wfill_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    for (int i = 0; i <= AW; i++) gray2bin[i] = ^(g >> i);
  endfunction

  assign accept         = in_valid_i & in_ready_q;
  assign winc_o         = (state_q != EMPTY) & ~wfull_i;
  assign wdata_o        = main_q;
  assign in_ready_o     = in_ready_q;
  assign rptr_sync_o    = sync_q[SYNC_STAGES-1];
  assign wfill_o        = wfill_q;
  assign walmost_full_o = walmost_full_q;
  // Modulo subtract absorbs the pointer MSB wrap.
  assign wfill_d        = gray2bin(wptr_i) - gray2bin(rptr_sync_o);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = in_data_i;
      end
      // Head leaving and new word arriving together: new word becomes the head.
      ONE: if (accept && winc_o) main_d = in_data_i;
      else if (accept) begin
        state_d = TWO;
        skid_d  = in_data_i;
      end else if (winc_o) state_d = EMPTY;
      TWO: if (winc_o) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q        <= EMPTY;
      main_q         <= '0;
      skid_q         <= '0;
      in_ready_q     <= 1'b0;
      wfill_q        <= '0;
      walmost_full_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      main_q         <= main_d;
      skid_q         <= skid_d;
      in_ready_q     <= state_d != TWO;
      wfill_q        <= wfill_d;
      walmost_full_q <= wfill_d >= AF_TH;
      sync_q[0]      <= rptr_async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef FIFO_WR_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) stall_q <= '0;
    else if (state_q != EMPTY && wfull_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign wstall_cnt_o = stall_q;
`else
  assign wstall_cnt_o = 16'h0;
`endif
endmodule
